layer_serializer: RTL and testbench
===================================

# layer_serializer

Collects the parallel results of one layer's neurons and replays them as a serial stream for the next layer, whose neurons consume one input per cycle on a data/valid pair. It sits between the neuron array of layer N and the input ports of layer N+1. Each captured word can pass through an optional ReLU. One full layer vector is buffered, and a sticky flag reports when new results arrive while the buffer is still busy.

## Interface
- NUM_NEURONS, 10: neurons in the upstream layer, which is also the length of the serial burst; ≥ 2.
- DATA_WIDTH, 16: width of each neuron result, two's complement.
- ACT_RELU, 1: 1 applies ReLU at capture; 0 passes data through unchanged.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  NUM_NEURONS*DATA_WIDTH  neuron results; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_NEURONS  per-neuron one-cycle result strobe.
- out_data  out  DATA_WIDTH  serial word to the next layer.
- out_valid  out  1  out_data is valid this cycle.
- busy  out  1  high while the block is replaying a burst (state SHIFT).
- overrun  out  1  sticky; a result was dropped.

## Operation
- State machine with two states.
  - COLLECT is the reset state.
  - SHIFT replays the buffer.
- Each cycle in COLLECT, for every k with in_valid[k]=1:
  - If mask[k]=0: buf[k] <= act(in_data slice k) and mask[k] <= 1.
  - If mask[k]=1: the word is dropped, buf[k] is unchanged, and overrun <= 1.
- Several bits of in_valid may be set in the same cycle. Each bit is handled independently.
- When the mask including this cycle's captures is all ones: state <= SHIFT, idx <= 0, mask <= 0.
- Each cycle in SHIFT:
  - out_data <= buf[idx], out_valid <= 1, idx <= idx+1.
  - On idx == NUM_NEURONS-1: state <= COLLECT.
- Any in_valid bit set while in SHIFT drops the word and sets overrun <= 1. This includes the final SHIFT cycle.
- Each cycle not in SHIFT, out_valid <= 0. out_data holds its last value.
- act(x):
  - ACT_RELU=1: x[DATA_WIDTH-1]=1 gives 0; otherwise x.
  - ACT_RELU=0: x.
  - No width change and no saturation.
- idx width is $clog2(NUM_NEURONS). idx never wraps past NUM_NEURONS-1.
- overrun is cleared only by rst.
- rst mid-burst aborts the burst. Buffered data is discarded; buf contents need no reset.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, overrun=0, state=COLLECT, mask=0, idx=0.
- Let E be the edge that completes the mask.
  - busy is high from E to E+NUM_NEURONS. It is a combinational decode of state.
  - out_valid is high for exactly NUM_NEURONS contiguous cycles, after edges E+1 … E+NUM_NEURONS.
  - Word order is neuron 0 first, then neuron NUM_NEURONS-1 last.
- Latency from the last capturing edge to the first out_valid: 1 cycle.
- Minimum period between bursts: NUM_NEURONS+1 cycles. The next capture is accepted at edge E+NUM_NEURONS+1.
- No backpressure. The downstream layer must accept one word per cycle.

## Structure
- Shared package nn_pkg holds the state enum (COLLECT, SHIFT) and a relu function parameterised by width. The downstream activation blocks reuse the same function.
- One natural sub-module: act_unit (the combinational ReLU/bypass on one word), instantiated NUM_NEURONS times in a generate loop on the capture path.
- buf is a register array, not RAM, because all lanes need parallel writes.

## Test plan
- Simultaneous capture, NUM_NEURONS=4, DATA_WIDTH=16, ACT_RELU=1.
  - Stimulus: in_valid=4'b1111 for one cycle with lanes {0x0005, 0xFFFE, 0x7FFF, 0x0000}.
  - Required: after 1 cycle, out_valid high for 4 cycles carrying 0x0005, 0x0000, 0x7FFF, 0x0000.
  - Required: busy high for 4 cycles starting at the capture edge; overrun stays 0.
- Staggered capture.
  - Stimulus: in_valid bits 2, then 0, then 3, then 1 on consecutive cycles.
  - Required: no out_valid until the cycle after bit 1's edge, then lane order 0..3.
- Overrun in COLLECT.
  - Stimulus: in_valid[1] twice before the other lanes arrive, first 0x0011 then 0x0022.
  - Required: the burst carries 0x0011 in slot 1; overrun=1 and stays 1 until rst.
- Overrun in SHIFT.
  - Stimulus: in_valid=4'b1111 during the 3rd burst word.
  - Required: the data is dropped, overrun=1, the current burst is unaltered, and no second burst is emitted.
- Reset mid-burst.
  - Stimulus: assert rst after the 2nd output word.
  - Required: out_valid=0 and busy=0 the next cycle.
  - Required: a fresh 4'b1111 capture then yields a full 4-word burst.
- Bypass, ACT_RELU=0.
  - Stimulus: lanes {0x8000, 0xFFFF, 1, 2}.
  - Required: the output is identical to the input in the same order.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared neural-network helpers: serializer state encoding and ReLU.
package nn_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    SHIFT   = 1'b1
  } state_t;

  // Widest word the shared relu helper handles; callers zero-extend into it.
  localparam int unsigned RELU_MAX_W = 64;

  // ReLU on a two's complement word of 'width' bits held in the low bits of x.
  function automatic logic [RELU_MAX_W-1:0] relu(input logic [RELU_MAX_W-1:0] x,
                                                 input int unsigned           width);
    logic [RELU_MAX_W-1:0] y;
    y = x;
    if (x[width-1]) y = '0;
    return y;
  endfunction

endpackage

// File: rtl/act_unit.sv
// Combinational activation on one neuron word: ReLU or pass-through.
module act_unit
  import nn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACT_RELU   = 1
) (
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);

  // Select ReLU result (truncated back to word width) or raw word
  always_comb begin
    if (ACT_RELU != 0) y = DATA_WIDTH'(relu(RELU_MAX_W'(x), DATA_WIDTH));
    else               y = x;
  end

endmodule

// File: rtl/layer_serializer.sv
// Buffers one layer's parallel neuron results and replays them serially,
// neuron 0 first, one word per cycle. Sticky overrun flags dropped results.
module layer_serializer
  import nn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACT_RELU    = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic                              busy,
  output logic                              overrun
);

  localparam int unsigned       IDX_W    = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_NEURONS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [NUM_NEURONS-1:0]  mask;
  logic [NUM_NEURONS-1:0]  mask_merged;
  logic [NUM_NEURONS-1:0]  capture;
  logic                    drop;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   act_data [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]   buf_mem  [NUM_NEURONS];

  for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_act
    act_unit #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACT_RELU  (ACT_RELU)
    ) u_act (
      .x(in_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .y(act_data[k])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  // Per-lane capture/drop decode and next-state selection
  always_comb begin
    capture     = '0;
    drop        = 1'b0;
    mask_merged = mask;
    state_next  = state;
    case (state)
      COLLECT: begin
        capture     = in_valid & ~mask;
        drop        = |(in_valid & mask);
        mask_merged = mask | in_valid;
        if (&mask_merged) state_next = SHIFT;
      end
      SHIFT: begin
        drop = |in_valid;
        if (idx == IDX_LAST) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Output decode: busy reflects the replay state directly
  always_comb begin
    busy = (state == SHIFT);
  end

  // Control and serial output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mask      <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (drop) overrun <= 1'b1;
      out_valid <= (state == SHIFT);
      case (state)
        COLLECT: begin
          // idx is held at 0 throughout COLLECT, so entering SHIFT starts at neuron 0
          mask <= (state_next == SHIFT) ? '0 : mask_merged;
          idx  <= '0;
        end
        SHIFT: begin
          out_data <= buf_mem[idx];
          idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Layer buffer: parallel lane writes, contents need no reset
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
      if (capture[k]) buf_mem[k] <= act_data[k];
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// Bench for layer_serializer: ReLU and bypass instances share stimulus;
// a timing-level model is compared every cycle, directed bursts are pinned
// against hand-computed words.
module tb_layer_serializer;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;

  logic [W-1:0] od_r, od_b;
  logic         ov_r, ov_b, busy_r, busy_b, orun_r, orun_b;

  always #5 clk = ~clk;

  layer_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(W), .ACT_RELU(1)) dut_relu (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(od_r), .out_valid(ov_r), .busy(busy_r), .overrun(orun_r));

  layer_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(W), .ACT_RELU(0)) dut_byp (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(od_b), .out_valid(ov_b), .busy(busy_b), .overrun(orun_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_relu(input logic [W-1:0] x);
    return x[W-1] ? '0 : x;
  endfunction

  // ---------------- model: burst timing derived from the capture edge ------
  int           cyc = 0;
  int           burst_edge = -100;
  bit           filled [N];
  logic [W-1:0] held_r [N];
  logic [W-1:0] held_b [N];
  logic [W-1:0] m_od_r = '0, m_od_b = '0;
  bit           m_ov = 0, m_busy = 0, m_orun = 0, model_live = 0;

  always @(posedge clk) begin
    int j;
    bit all;
    cyc++;
    if (rst) begin
      for (int k = 0; k < N; k++) filled[k] = 0;
      burst_edge = -100;
      m_orun = 0; m_ov = 0; m_od_r = '0; m_od_b = '0;
      model_live = 1;
    end else begin
      j = cyc - burst_edge;
      if (j >= 1 && j <= N) begin
        m_ov   = 1;
        m_od_r = held_r[j-1];
        m_od_b = held_b[j-1];
        if (|in_valid) m_orun = 1;
      end else begin
        m_ov = 0;
        for (int k = 0; k < N; k++) begin
          if (in_valid[k]) begin
            if (filled[k]) m_orun = 1;
            else begin
              filled[k] = 1;
              held_b[k] = in_data[k*W +: W];
              held_r[k] = m_relu(in_data[k*W +: W]);
            end
          end
        end
        all = 1;
        for (int k = 0; k < N; k++) all &= filled[k];
        if (all) begin
          burst_edge = cyc;
          for (int k = 0; k < N; k++) filled[k] = 0;
        end
      end
    end
    m_busy = ((cyc - burst_edge) >= 0) && ((cyc - burst_edge) <= N-1);
  end

  // Every-cycle compare against the model
  always @(posedge clk) begin
    #1;
    if (model_live) begin
      chk("out_valid_r", {31'b0, ov_r},   {31'b0, m_ov});
      chk("out_valid_b", {31'b0, ov_b},   {31'b0, m_ov});
      chk("out_data_r",  {16'b0, od_r},   {16'b0, m_od_r});
      chk("out_data_b",  {16'b0, od_b},   {16'b0, m_od_b});
      chk("busy_r",      {31'b0, busy_r}, {31'b0, m_busy});
      chk("busy_b",      {31'b0, busy_b}, {31'b0, m_busy});
      chk("overrun_r",   {31'b0, orun_r}, {31'b0, m_orun});
      chk("overrun_b",   {31'b0, orun_b}, {31'b0, m_orun});
    end
  end

  // Collect emitted words for the directed literal checks
  logic [W-1:0] got_r[$];
  logic [W-1:0] got_b[$];
  always @(posedge clk) begin
    #1;
    if (ov_r) got_r.push_back(od_r);
    if (ov_b) got_b.push_back(od_b);
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [N-1:0] v, input logic [W-1:0] d0, d1, d2, d3);
    in_valid = v;
    in_data  = {d3, d2, d1, d0};
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic chk_burst(input string name, input bit bypass, input int n,
                           input logic [W-1:0] e0, e1, e2, e3);
    logic [W-1:0] e [4];
    int sz;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    sz = bypass ? got_b.size() : got_r.size();
    chk({name, "_count"}, sz, n);
    for (int i = 0; i < n && i < sz; i++)
      chk($sformatf("%s_word%0d", name, i), {16'b0, bypass ? got_b[i] : got_r[i]}, {16'b0, e[i]});
  endtask

  task automatic clear_q();
    got_r.delete();
    got_b.delete();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", {31'b0, ov_r},   0);
    chk("reset_busy",      {31'b0, busy_r}, 0);
    chk("reset_overrun",   {31'b0, orun_r}, 0);
    chk("reset_out_data",  {16'b0, od_r},   0);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous capture
    clear_q();
    drive(4'b1111, 16'h0005, 16'hFFFE, 16'h7FFF, 16'h0000);
    chk("t1_busy_at_capture", {31'b0, busy_r}, 1);
    chk("t1_no_valid_yet",    {31'b0, ov_r},   0);
    repeat (6) @(negedge clk);
    chk_burst("t1_relu", 0, 4, 16'h0005, 16'h0000, 16'h7FFF, 16'h0000);
    chk_burst("t1_byp",  1, 4, 16'h0005, 16'hFFFE, 16'h7FFF, 16'h0000);
    chk("t1_overrun", {31'b0, orun_r}, 0);

    // Staggered capture: lanes 2, 0, 3, 1
    clear_q();
    drive(4'b0100, 16'h0100, 16'h0101, 16'h0102, 16'h0103);
    drive(4'b0001, 16'h0100, 16'h0101, 16'h0102, 16'h0103);
    drive(4'b1000, 16'h0100, 16'h0101, 16'h0102, 16'h0103);
    chk("t2_idle_before_last", {31'b0, busy_r}, 0);
    drive(4'b0010, 16'h0100, 16'h0101, 16'h0102, 16'h0103);
    chk("t2_no_valid_at_capture", {31'b0, ov_r}, 0);
    repeat (6) @(negedge clk);
    chk_burst("t2_relu", 0, 4, 16'h0100, 16'h0101, 16'h0102, 16'h0103);

    // Overrun in COLLECT: second lane-1 word is dropped
    clear_q();
    drive(4'b0010, 16'h0000, 16'h0011, 16'h0000, 16'h0000);
    drive(4'b0010, 16'h0000, 16'h0022, 16'h0000, 16'h0000);
    chk("t3_overrun_set", {31'b0, orun_r}, 1);
    drive(4'b1101, 16'h000A, 16'h0033, 16'h000C, 16'h000D);
    repeat (6) @(negedge clk);
    chk_burst("t3_relu", 0, 4, 16'h000A, 16'h0011, 16'h000C, 16'h000D);
    chk("t3_overrun_sticky", {31'b0, orun_r}, 1);

    // Overrun in SHIFT: 4'b1111 while word 3 is presented
    pulse_rst();
    chk("t4_overrun_cleared", {31'b0, orun_r}, 0);
    clear_q();
    drive(4'b1111, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    repeat (3) @(negedge clk);
    chk("t4_third_word_shown", {16'b0, od_r}, 16'h0003);
    drive(4'b1111, 16'h0055, 16'h0066, 16'h0077, 16'h0088);
    repeat (8) @(negedge clk);
    chk_burst("t4_relu", 0, 4, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    chk("t4_overrun", {31'b0, orun_r}, 1);

    // Reset mid-burst, then a fresh full burst
    pulse_rst();
    clear_q();
    drive(4'b1111, 16'h0021, 16'h0022, 16'h0023, 16'h0024);
    repeat (2) @(negedge clk);
    pulse_rst();
    chk("t5_valid_after_rst", {31'b0, ov_r},   0);
    chk("t5_busy_after_rst",  {31'b0, busy_r}, 0);
    repeat (3) @(negedge clk);
    chk_burst("t5_partial", 0, 2, 16'h0021, 16'h0022, 16'h0000, 16'h0000);
    clear_q();
    drive(4'b1111, 16'h0031, 16'h0032, 16'h0033, 16'h0034);
    repeat (6) @(negedge clk);
    chk_burst("t5_fresh", 0, 4, 16'h0031, 16'h0032, 16'h0033, 16'h0034);

    // Bypass versus ReLU on negative lanes
    clear_q();
    drive(4'b1111, 16'h8000, 16'hFFFF, 16'h0001, 16'h0002);
    repeat (6) @(negedge clk);
    chk_burst("t6_byp",  1, 4, 16'h8000, 16'hFFFF, 16'h0001, 16'h0002);
    chk_burst("t6_relu", 0, 4, 16'h0000, 16'h0000, 16'h0001, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
